// File: rtl/cpu_pkg.sv
// Shared types and constants for the microcoded CPU controller.
package cpu_pkg;

  localparam int NUM_STEPS = 5;
  localparam int STEP_W    = 3;

  localparam logic [STEP_W-1:0] T0 = 3'd0;
  localparam logic [STEP_W-1:0] T1 = 3'd1;
  localparam logic [STEP_W-1:0] T2 = 3'd2;
  localparam logic [STEP_W-1:0] T3 = 3'd3;
  localparam logic [STEP_W-1:0] T4 = 3'd4;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'he,
    OP_HLT = 4'hf
  } opcode_e;

  typedef struct packed {
    logic halt;
    logic mi;
    logic ri;
    logic ro;
    logic ii;
    logic io;
    logic ai;
    logic ao;
    logic so;
    logic subtract;
    logic bi;
    logic oi;
    logic ce;
    logic co;
    logic j;
    logic flags_in;
  } ctrl_word_t;

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode decode: (T-state, opcode, flags) -> control word.
module microcode_rom
  import cpu_pkg::*;
(
  input  logic [STEP_W-1:0] i_step,
  input  logic [3:0]        i_opcode,
  input  logic              i_carry,
  input  logic              i_zero,
  output ctrl_word_t        o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_step)
      T0: begin
        o_ctrl.co = 1'b1;
        o_ctrl.mi = 1'b1;
      end
      T1: begin
        o_ctrl.ro = 1'b1;
        o_ctrl.ii = 1'b1;
        o_ctrl.ce = 1'b1;
      end
      default: begin
        // Opcode is only meaningful once IR has loaded at the end of T1.
        case (opcode_e'(i_opcode))
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            if (i_step == T2) begin
              o_ctrl.io = 1'b1;
              o_ctrl.mi = 1'b1;
            end else if (i_step == T3) begin
              o_ctrl.ro = (opcode_e'(i_opcode) != OP_STA);
              o_ctrl.ai = (opcode_e'(i_opcode) == OP_LDA);
              o_ctrl.bi = (opcode_e'(i_opcode) == OP_ADD) || (opcode_e'(i_opcode) == OP_SUB);
              o_ctrl.ao = (opcode_e'(i_opcode) == OP_STA);
              o_ctrl.ri = (opcode_e'(i_opcode) == OP_STA);
            end else if ((i_step == T4) &&
                         ((opcode_e'(i_opcode) == OP_ADD) || (opcode_e'(i_opcode) == OP_SUB))) begin
              o_ctrl.so       = 1'b1;
              o_ctrl.ai       = 1'b1;
              o_ctrl.flags_in = 1'b1;
              o_ctrl.subtract = (opcode_e'(i_opcode) == OP_SUB);
            end
          end
          OP_LDI: begin
            o_ctrl.io = (i_step == T2);
            o_ctrl.ai = (i_step == T2);
          end
          OP_JMP, OP_JC, OP_JZ: begin
            if ((i_step == T2) &&
                ((opcode_e'(i_opcode) == OP_JMP) ||
                 ((opcode_e'(i_opcode) == OP_JC) && i_carry) ||
                 ((opcode_e'(i_opcode) == OP_JZ) && i_zero))) begin
              o_ctrl.io = 1'b1;
              o_ctrl.j  = 1'b1;
            end
          end
          OP_OUT: begin
            o_ctrl.ao = (i_step == T2);
            o_ctrl.oi = (i_step == T2);
          end
          OP_HLT: o_ctrl.halt = (i_step == T2);
          default: o_ctrl = '0;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Microcode sequencer: T-state counter, sticky halt and control-word gating.
// step | meaning
// 0    | T0 fetch: PC -> MAR
// 1    | T1 fetch: RAM -> IR, PC++
// 2-4  | T2..T4 execute, decoded from opcode; frozen at 2 once halted
module control_unit
  import cpu_pkg::*;
#(
  parameter int NUM_STEPS = cpu_pkg::NUM_STEPS
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [3:0]        i_opcode,
  input  logic              i_carry,
  input  logic              i_zero,
  output logic              o_halt,
  output logic              o_mi,
  output logic              o_ri,
  output logic              o_ro,
  output logic              o_ii,
  output logic              o_io,
  output logic              o_ai,
  output logic              o_ao,
  output logic              o_so,
  output logic              o_subtract,
  output logic              o_bi,
  output logic              o_oi,
  output logic              o_ce,
  output logic              o_co,
  output logic              o_j,
  output logic              o_flags_in,
  output logic [STEP_W-1:0] o_step
);

  logic [STEP_W-1:0] r_step;
  logic              r_halted;
  ctrl_word_t        w_rom;
  ctrl_word_t        w_ctrl;

  microcode_rom u_rom (
    .i_step   (r_step),
    .i_opcode (i_opcode),
    .i_carry  (i_carry),
    .i_zero   (i_zero),
    .o_ctrl   (w_rom)
  );

  // The HLT edge does not advance the step, so a halted unit sits at T2.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_step   <= '0;
      r_halted <= 1'b0;
    end else if (!r_halted) begin
      if (w_rom.halt)
        r_halted <= 1'b1;
      else if (r_step == STEP_W'(NUM_STEPS - 1))
        r_step <= '0;
      else
        r_step <= r_step + 1'b1;
    end
  end

  always_comb begin
    w_ctrl = '0;
    if (!i_rst) begin
      if (r_halted)
        w_ctrl.halt = 1'b1;
      else
        w_ctrl = w_rom;
    end
  end

  assign o_halt     = w_ctrl.halt;
  assign o_mi       = w_ctrl.mi;
  assign o_ri       = w_ctrl.ri;
  assign o_ro       = w_ctrl.ro;
  assign o_ii       = w_ctrl.ii;
  assign o_io       = w_ctrl.io;
  assign o_ai       = w_ctrl.ai;
  assign o_ao       = w_ctrl.ao;
  assign o_so       = w_ctrl.so;
  assign o_subtract = w_ctrl.subtract;
  assign o_bi       = w_ctrl.bi;
  assign o_oi       = w_ctrl.oi;
  assign o_ce       = w_ctrl.ce;
  assign o_co       = w_ctrl.co;
  assign o_j        = w_ctrl.j;
  assign o_flags_in = w_ctrl.flags_in;
  assign o_step     = r_step;

endmodule
